mig_app_responder: RTL and testbench
====================================

Name: mig_app_responder

Overview:
- Synthesizable, BRAM-backed responder for the MIG 7-series application (UI) interface: the far end of the app_* handshake that ddr_controller drives.
- Stands in for mig_7series_0 in block-level simulation and on boards without DDR3, so the DDR_cache_interface/ddr_controller chain runs without the PHY.
- Accepts read/write commands and write-data beats, stores them in an internal array, and returns read data in order after a fixed latency.

Parameters:
- DDR_DATA_WIDTH, 128, width of app_wdf_data/app_rd_data.
- DDR_ADDR_WIDTH, 28, width of app_addr.
- MEM_DEPTH, 256, number of DDR_DATA_WIDTH words stored; power of 2.
- RD_LATENCY, 4, pipeline cycles from read issue to app_rd_data_valid; ≥1.
- CMD_FIFO_DEPTH, 4, command queue entries; power of 2.
- WDF_FIFO_DEPTH, 4, write-data queue entries; power of 2.
- CALIB_CYCLES, 16, cycles after reset release before init_calib_complete.
- STALL_PERIOD, 0, if nonzero, app_rdy is forced low one cycle in every STALL_PERIOD cycles; 0 disables.

Ports:
- clk  in  1  UI clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- init_calib_complete  out  1  high once calibration emulation is done.
- app_addr  in  DDR_ADDR_WIDTH  command address (16-bit column units).
- app_cmd  in  3  3'b000 write, 3'b001 read.
- app_en  in  1  command valid.
- app_rdy  out  1  command accept.
- app_wdf_data  in  DDR_DATA_WIDTH  write beat.
- app_wdf_wren  in  1  write beat valid.
- app_wdf_end  in  1  last beat of burst.
- app_wdf_mask  in  DDR_DATA_WIDTH/8  byte mask; 1 = byte not written.
- app_wdf_rdy  out  1  write beat accept.
- app_rd_data  out  DDR_DATA_WIDTH  read beat.
- app_rd_data_valid  out  1  read beat valid.
- app_rd_data_end  out  1  last read beat.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (rst_n=0 at an edge): init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, protocol_err = 0; app_rd_data = 0; calib counter, FIFOs and read pipeline cleared. Memory contents are NOT cleared. Reset mid-burst drops all in-flight commands, data and reads.
- Calibration: counter runs from reset release; init_calib_complete goes high CALIB_CYCLES edges later and stays high. app_rdy and app_wdf_rdy are held 0 until then.
- app_rdy = calib && cmd FIFO not full && not stall cycle. app_wdf_rdy = calib && WDF FIFO not full. Both are combinational from registered state; never depend on app_en/app_wdf_wren.
- Command accept: app_en && app_rdy at an edge. Opcodes other than 000/001 are accepted, dropped, and set protocol_err.
- Word index = app_addr[3 +: log2(MEM_DEPTH)], one 128-bit BL8 word per 8 addresses; higher bits ignored (wrap modulo MEM_DEPTH); app_addr[2:0] ≠ 0 sets protocol_err, access proceeds on the aligned word.
- Beat accept: app_wdf_wren && app_wdf_rdy. One beat per burst, so app_wdf_end must equal app_wdf_wren; a mismatch sets protocol_err and the beat is still queued.
- Data may arrive before, with, or after its write command; pairing is strictly FIFO order.
- Execution: one head command per cycle, in order. Read head issues into the RD_LATENCY pipeline. Write head commits only when the WDF FIFO is non-empty: masked byte write, pop both. Otherwise the head stalls and blocks later reads.
- Read timing: the earliest head issue is the edge after acceptance. For a read accepted at edge N into an empty queue, valid and end are high for exactly one cycle, sampled at edge N+1+RD_LATENCY. app_rd_data_end = app_rd_data_valid.
- Ordering: a read sees every write that committed before it issued (read-after-write coherent in queue order).
- Simultaneous accept and pop on a full FIFO is allowed; occupancy is unchanged.
- No read-data backpressure: the consumer must take every beat.

Test Plan:
- Reset release, rst_n held high -> init_calib_complete rises at edge 16; app_rdy=0 before; app_rdy=1 from edge 16.
- Write addr 0x000_0010, data 128'h0123…CDEF, mask 0, then read 0x10 accepted at edge N -> app_rd_data_valid/app_rd_data_end high at edge N+5 with the same data.
- Write 0x10 with 128'hFF…FF and mask 16'h00FF -> read 0x10 shows upper 8 bytes all FF, lower 8 bytes keep the previous value.
- Write command at edge N with data delayed 3 cycles, followed by read of the same addr -> read is held behind the write and returns the new data; no protocol_err.
- 5 back-to-back reads with CMD_FIFO_DEPTH=4 and no head drain (write at head lacking data) -> app_rdy=0 after 4 accepts; supply data -> queue drains and reads return in order.
- app_addr 0x0000_0803 with MEM_DEPTH=256 -> protocol_err=1 (misaligned); access aliases word 0; protocol_err stays 1 until rst_n=0.

Source files
------------

// File: rtl/mig_app_responder_if.sv
// MIG 7-series UI application bus.
// master = ddr_controller side, slave = memory responder side.
interface mig_app_responder_if #(
   parameter int DDR_DATA_WIDTH = 128,
   parameter int DDR_ADDR_WIDTH = 28
);
   logic                        init_calib_complete;
   logic [DDR_ADDR_WIDTH-1:0]   app_addr;
   logic [2:0]                  app_cmd;
   logic                        app_en;
   logic                        app_rdy;
   logic [DDR_DATA_WIDTH-1:0]   app_wdf_data;
   logic                        app_wdf_wren;
   logic                        app_wdf_end;
   logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask;
   logic                        app_wdf_rdy;
   logic [DDR_DATA_WIDTH-1:0]   app_rd_data;
   logic                        app_rd_data_valid;
   logic                        app_rd_data_end;
   logic                        protocol_err;

   modport master (
      input  init_calib_complete,
      input  app_rdy,
      input  app_wdf_rdy,
      input  app_rd_data,
      input  app_rd_data_valid,
      input  app_rd_data_end,
      input  protocol_err,
      output app_addr,
      output app_cmd,
      output app_en,
      output app_wdf_data,
      output app_wdf_wren,
      output app_wdf_end,
      output app_wdf_mask
   );

   modport slave (
      output init_calib_complete,
      output app_rdy,
      output app_wdf_rdy,
      output app_rd_data,
      output app_rd_data_valid,
      output app_rd_data_end,
      output protocol_err,
      input  app_addr,
      input  app_cmd,
      input  app_en,
      input  app_wdf_data,
      input  app_wdf_wren,
      input  app_wdf_end,
      input  app_wdf_mask
   );
endinterface

// File: rtl/mig_app_responder.sv
// BRAM-backed stand-in for the MIG 7-series UI: queues commands and
// write beats, commits in order and returns reads after fixed latency.
module mig_app_responder #(
   parameter int DDR_DATA_WIDTH = 128,
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int MEM_DEPTH      = 256,
   parameter int RD_LATENCY     = 4,
   parameter int CMD_FIFO_DEPTH = 4,
   parameter int WDF_FIFO_DEPTH = 4,
   parameter int CALIB_CYCLES   = 16,
   parameter int STALL_PERIOD   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   mig_app_responder_if.slave app
);
   localparam int DW    = DDR_DATA_WIDTH;
   localparam int BYTES = DDR_DATA_WIDTH / 8;
   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int CE_W  = IDX_W + 1;
   localparam int CP_W  = $clog2(CMD_FIFO_DEPTH);
   localparam int WP_W  = $clog2(WDF_FIFO_DEPTH);
   localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
   localparam int SP    = (STALL_PERIOD > 0) ? STALL_PERIOD : 1;
   localparam int SP_W  = $clog2(SP + 1);

   logic [CAL_W-1:0] r_calib_cnt;
   logic             r_calib;
   logic [SP_W-1:0]  r_stall_cnt;

   logic [CE_W-1:0]  r_cmd_mem [CMD_FIFO_DEPTH];
   logic [CP_W-1:0]  r_cmd_wp;
   logic [CP_W-1:0]  r_cmd_rp;
   logic [CP_W:0]    r_cmd_cnt;

   logic [DW-1:0]    r_wdf_data [WDF_FIFO_DEPTH];
   logic [BYTES-1:0] r_wdf_mask [WDF_FIFO_DEPTH];
   logic [WP_W-1:0]  r_wdf_wp;
   logic [WP_W-1:0]  r_wdf_rp;
   logic [WP_W:0]    r_wdf_cnt;

   logic [DW-1:0]    r_mem [MEM_DEPTH];

   logic [RD_LATENCY-1:0] r_pvld;
   logic [DW-1:0]         r_pdata [RD_LATENCY];
   logic                  r_rd_valid;
   logic [DW-1:0]         r_rd_data;
   logic                  r_err;

   logic             w_stall;
   logic             w_cmd_full;
   logic             w_wdf_full;
   logic [CE_W-1:0]  w_head;
   logic             w_head_vld;
   logic             w_head_rd;
   logic [IDX_W-1:0] w_head_idx;
   logic             w_wdf_vld;
   logic             w_rd_issue;
   logic             w_wr_commit;
   logic             w_cmd_pop;
   logic             w_wdf_pop;
   logic             w_rdy;
   logic             w_wdf_rdy;
   logic             w_cmd_acc;
   logic             w_cmd_ok;
   logic             w_cmd_push;
   logic             w_beat_acc;
   logic             w_err_set;
   logic [DW-1:0]    w_wdata;
   logic [BYTES-1:0] w_wmask;
   logic             w_unused_addr;

   assign w_unused_addr =
      ^{app.app_addr[DDR_ADDR_WIDTH-1:3+IDX_W]};

   assign w_stall = (STALL_PERIOD != 0) &&
                    (r_stall_cnt == SP_W'(SP - 1));

   assign w_cmd_full = r_cmd_cnt == (CP_W+1)'(CMD_FIFO_DEPTH);
   assign w_wdf_full = r_wdf_cnt == (WP_W+1)'(WDF_FIFO_DEPTH);

   assign w_head     = r_cmd_mem[r_cmd_rp];
   assign w_head_vld = r_cmd_cnt != '0;
   assign w_head_rd  = w_head[IDX_W];
   assign w_head_idx = w_head[IDX_W-1:0];
   assign w_wdf_vld  = r_wdf_cnt != '0;
   assign w_wdata    = r_wdf_data[r_wdf_rp];
   assign w_wmask    = r_wdf_mask[r_wdf_rp];

   // A write at the head waits for its beat and blocks everything behind it.
   assign w_rd_issue  = w_head_vld && w_head_rd;
   assign w_wr_commit = w_head_vld && !w_head_rd && w_wdf_vld;
   assign w_cmd_pop   = w_rd_issue || w_wr_commit;
   assign w_wdf_pop   = w_wr_commit;

   assign w_rdy     = r_calib && (!w_cmd_full || w_cmd_pop) && !w_stall;
   assign w_wdf_rdy = r_calib && (!w_wdf_full || w_wdf_pop);

   assign w_cmd_acc  = app.app_en && w_rdy;
   assign w_cmd_ok   = (app.app_cmd == 3'b000) ||
                       (app.app_cmd == 3'b001);
   assign w_cmd_push = w_cmd_acc && w_cmd_ok;
   assign w_beat_acc = app.app_wdf_wren && w_wdf_rdy;

   assign w_err_set =
      (w_cmd_acc && (!w_cmd_ok || (app.app_addr[2:0] != 3'b000))) ||
      (w_beat_acc && !app.app_wdf_end);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_calib_cnt <= '0;
         r_calib     <= 1'b0;
         r_stall_cnt <= '0;
         r_err       <= 1'b0;
      end else begin
         if (!r_calib) begin
            r_calib_cnt <= r_calib_cnt + CAL_W'(1);
            r_calib     <= r_calib_cnt == CAL_W'(CALIB_CYCLES - 1);
         end
         if (r_stall_cnt == SP_W'(SP - 1)) r_stall_cnt <= '0;
         else r_stall_cnt <= r_stall_cnt + SP_W'(1);
         if (w_err_set) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cmd_wp  <= '0;
         r_cmd_rp  <= '0;
         r_cmd_cnt <= '0;
         r_wdf_wp  <= '0;
         r_wdf_rp  <= '0;
         r_wdf_cnt <= '0;
      end else begin
         if (w_cmd_push) r_cmd_wp <= r_cmd_wp + CP_W'(1);
         if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + CP_W'(1);
         unique case ({w_cmd_push, w_cmd_pop})
            2'b10:   r_cmd_cnt <= r_cmd_cnt + (CP_W+1)'(1);
            2'b01:   r_cmd_cnt <= r_cmd_cnt - (CP_W+1)'(1);
            default: r_cmd_cnt <= r_cmd_cnt;
         endcase
         if (w_beat_acc) r_wdf_wp <= r_wdf_wp + WP_W'(1);
         if (w_wdf_pop)  r_wdf_rp <= r_wdf_rp + WP_W'(1);
         unique case ({w_beat_acc, w_wdf_pop})
            2'b10:   r_wdf_cnt <= r_wdf_cnt + (WP_W+1)'(1);
            2'b01:   r_wdf_cnt <= r_wdf_cnt - (WP_W+1)'(1);
            default: r_wdf_cnt <= r_wdf_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_cmd_push)
         r_cmd_mem[r_cmd_wp] <= {app.app_cmd[0],
                                 app.app_addr[3 +: IDX_W]};
      if (w_beat_acc) begin
         r_wdf_data[r_wdf_wp] <= app.app_wdf_data;
         r_wdf_mask[r_wdf_wp] <= app.app_wdf_mask;
      end
   end

   // Storage is deliberately not reset so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr_commit) begin
         for (int b = 0; b < BYTES; b++) begin
            if (!w_wmask[b])
               r_mem[w_head_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      r_pdata[0] <= r_mem[w_head_idx];
      for (int k = 1; k < RD_LATENCY; k++)
         r_pdata[k] <= r_pdata[k-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pvld     <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_pvld[0] <= w_rd_issue;
         for (int k = 1; k < RD_LATENCY; k++)
            r_pvld[k] <= r_pvld[k-1];
         r_rd_valid <= r_pvld[RD_LATENCY-1];
         if (r_pvld[RD_LATENCY-1])
            r_rd_data <= r_pdata[RD_LATENCY-1];
      end
   end

   assign app.init_calib_complete = r_calib;
   assign app.app_rdy             = w_rdy;
   assign app.app_wdf_rdy         = w_wdf_rdy;
   assign app.app_rd_data         = r_rd_data;
   assign app.app_rd_data_valid   = r_rd_valid;
   assign app.app_rd_data_end     = r_rd_valid;
   assign app.protocol_err        = r_err;
endmodule

// File: tb/tb_mig_app_responder.sv
// Randomized self-checking bench for mig_app_responder against a
// queue-level memory model.
module tb_mig_app_responder;
   localparam int DW = 128;
   localparam int AW = 28;
   localparam int MD = 256;
   localparam int RL = 4;
   localparam int BY = DW / 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mig_app_responder_if #(.DDR_DATA_WIDTH(DW),
                          .DDR_ADDR_WIDTH(AW)) app ();

   mig_app_responder #(
      .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW),
      .MEM_DEPTH(MD), .RD_LATENCY(RL),
      .CMD_FIFO_DEPTH(4), .WDF_FIFO_DEPTH(4),
      .CALIB_CYCLES(16), .STALL_PERIOD(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .app(app)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int n_acc  = 0;
   int beat_cyc = 0;
   int end_mis  = 0;

   typedef struct packed { logic rd; int idx; } mcmd_t;
   logic [DW-1:0] m_mem [MD];
   mcmd_t         mq_c [$];
   logic [DW-1:0] mq_d [$];
   logic [BY-1:0] mq_m [$];
   logic [DW-1:0] exp_q [$];

   logic [DW-1:0] got_q [$];
   int            got_cyc_q [$];

   always @(posedge clk) begin
      cyc++;
      #1;
      if (app.app_rd_data_valid !== app.app_rd_data_end) end_mis++;
      if (app.app_rd_data_valid === 1'b1) begin
         got_q.push_back(app.app_rd_data);
         got_cyc_q.push_back(cyc);
      end
   end

   // Apply queued commands in order; a write waits for its beat.
   function automatic void m_drain();
      logic [DW-1:0] d;
      logic [BY-1:0] m;
      while (mq_c.size() > 0) begin
         if (mq_c[0].rd) begin
            exp_q.push_back(m_mem[mq_c[0].idx]);
            void'(mq_c.pop_front());
         end else if (mq_d.size() > 0) begin
            d = mq_d.pop_front();
            m = mq_m.pop_front();
            for (int b = 0; b < BY; b++)
               if (!m[b]) m_mem[mq_c[0].idx][b*8 +: 8] = d[b*8 +: 8];
            void'(mq_c.pop_front());
         end else break;
      end
   endfunction

   function automatic void clear_obs();
      got_q.delete();
      got_cyc_q.delete();
      exp_q.delete();
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_cmd(input logic [2:0] c,
                           input logic [AW-1:0] a);
      bit ok;
      ok = 1'b0;
      app.app_cmd  = c;
      app.app_addr = a;
      app.app_en   = 1'b1;
      for (int t = 0; t < 300 && !ok; t++) begin
         #7;
         ok = app.app_rdy;
         @(posedge clk);
         #1;
      end
      app.app_en = 1'b0;
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL cmd_timeout got=no accept required=accept");
      end else begin
         n_acc++;
         if (c == 3'b000 || c == 3'b001) begin
            mq_c.push_back('{rd: c[0], idx: (int'(a) / 8) % MD});
            m_drain();
         end
      end
   endtask

   task automatic send_beat(input logic [DW-1:0] d,
                            input logic [BY-1:0] m,
                            input logic e);
      bit ok;
      ok = 1'b0;
      app.app_wdf_data = d;
      app.app_wdf_mask = m;
      app.app_wdf_end  = e;
      app.app_wdf_wren = 1'b1;
      for (int t = 0; t < 300 && !ok; t++) begin
         #7;
         ok = app.app_wdf_rdy;
         @(posedge clk);
         #1;
      end
      app.app_wdf_wren = 1'b0;
      app.app_wdf_end  = 1'b0;
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL beat_timeout got=no accept required=accept");
      end else begin
         beat_cyc = cyc;
         mq_d.push_back(d);
         mq_m.push_back(m);
         m_drain();
      end
   endtask

   task automatic wait_reads(input int n);
      int t;
      t = 0;
      while (got_q.size() < n && t < 200) begin
         idle(1);
         t++;
      end
      if (got_q.size() < n) begin
         n_chk++;
         n_fail++;
         $display("FAIL read_timeout got=%0d required=%0d",
                  got_q.size(), n);
      end
   endtask

   task automatic wait_calib();
      int t;
      t = 0;
      while (app.init_calib_complete !== 1'b1 && t < 40) begin
         idle(1);
         t++;
      end
      if (app.init_calib_complete !== 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL calib_timeout got=%b required=1",
                  app.init_calib_complete);
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      idle(1);
      mq_c.delete();
      mq_d.delete();
      mq_m.delete();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic e;
      app.app_en = 1'b0; app.app_cmd = '0; app.app_addr = '0;
      app.app_wdf_wren = 1'b0; app.app_wdf_end = 1'b0;
      app.app_wdf_data = '0; app.app_wdf_mask = '0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      idle(2);
      n_chk++;
      if ({app.init_calib_complete, app.app_rdy, app.app_wdf_rdy,
           app.app_rd_data_valid, app.app_rd_data_end,
           app.protocol_err} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags got=%b%b%b%b%b%b required=000000",
                  app.init_calib_complete, app.app_rdy,
                  app.app_wdf_rdy, app.app_rd_data_valid,
                  app.app_rd_data_end, app.protocol_err);
      end
      n_chk++;
      if (app.app_rd_data !== '0) begin
         n_fail++;
         $display("FAIL reset_rd_data got=%h required=0",
                  app.app_rd_data);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         idle(1);
         e = (k >= 16);
         n_chk++;
         if (app.init_calib_complete !== e) begin
            n_fail++;
            $display("FAIL calib_edge%0d got=%b required=%b",
                     k, app.init_calib_complete, e);
         end
         n_chk++;
         if (app.app_rdy !== e || app.app_wdf_rdy !== e) begin
            n_fail++;
            $display("FAIL rdy_edge%0d got=%b%b required=%b%b",
                     k, app.app_rdy, app.app_wdf_rdy, e, e);
         end
      end
   endtask

   localparam logic [DW-1:0] D1 =
      128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

   task automatic test_write_read();
      int n;
      clear_obs();
      send_cmd(3'b000, 28'h000_0010);
      send_beat(D1, '0, 1'b1);
      send_cmd(3'b001, 28'h000_0010);
      n = cyc;
      wait_reads(1);
      if (got_q.size() >= 1) begin
         n_chk++;
         if (got_q[0] !== D1) begin
            n_fail++;
            $display("FAIL wr_rd_data got=%h required=%h", got_q[0], D1);
         end
         n_chk++;
         if (got_cyc_q[0] !== n + 1 + RL) begin
            n_fail++;
            $display("FAIL wr_rd_latency got=%0d required=%0d",
                     got_cyc_q[0], n + 1 + RL);
         end
      end
      idle(3);
      n_chk++;
      if (got_q.size() !== 1) begin
         n_fail++;
         $display("FAIL wr_rd_beats got=%0d required=1", got_q.size());
      end
   endtask

   task automatic test_mask();
      logic [DW-1:0] want;
      logic [DW-1:0] ones;
      ones = '1;
      want = {ones[127:64], D1[63:0]};
      clear_obs();
      send_cmd(3'b000, 28'h000_0010);
      send_beat(ones, 16'h00FF, 1'b1);
      send_cmd(3'b001, 28'h000_0010);
      wait_reads(1);
      if (got_q.size() >= 1) begin
         n_chk++;
         if (got_q[0] !== want || exp_q[0] !== want) begin
            n_fail++;
            $display("FAIL mask_data got=%h required=%h", got_q[0], want);
         end
      end
   endtask

   task automatic test_delayed_data();
      logic [DW-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      clear_obs();
      fork
         begin
            send_cmd(3'b000, 28'h000_0020);
            send_cmd(3'b001, 28'h000_0020);
         end
         begin
            idle(3);
            send_beat(d, '0, 1'b1);
         end
      join
      wait_reads(1);
      if (got_q.size() >= 1) begin
         n_chk++;
         if (got_q[0] !== d) begin
            n_fail++;
            $display("FAIL delayed_data got=%h required=%h", got_q[0], d);
         end
         n_chk++;
         if (got_cyc_q[0] < beat_cyc + 1 + RL) begin
            n_fail++;
            $display("FAIL delayed_order got=%0d required>=%0d",
                     got_cyc_q[0], beat_cyc + 1 + RL);
         end
      end
      n_chk++;
      if (app.protocol_err !== 1'b0) begin
         n_fail++;
         $display("FAIL delayed_err got=%b required=0", app.protocol_err);
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] ra [5];
      int a0;
      logic [DW-1:0] d;
      ra = '{28'h000_0030, 28'h000_0010, 28'h000_0020,
             28'h000_0830, 28'h000_0010};
      d = {$urandom, $urandom, $urandom, $urandom};
      clear_obs();
      a0 = n_acc;
      fork
         begin
            send_cmd(3'b000, 28'h000_0030);
            for (int i = 0; i < 5; i++) send_cmd(3'b001, ra[i]);
         end
         begin
            idle(8);
            n_chk++;
            if (app.app_rdy !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_rdy got=%b required=0", app.app_rdy);
            end
            n_chk++;
            if (n_acc - a0 !== 4) begin
               n_fail++;
               $display("FAIL b2b_accepts got=%0d required=4",
                        n_acc - a0);
            end
            send_beat(d, '0, 1'b1);
         end
      join
      wait_reads(5);
      n_chk++;
      if (got_q.size() !== 5 || exp_q.size() !== 5) begin
         n_fail++;
         $display("FAIL b2b_count got=%0d required=5", got_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL b2b_data%0d got=%h required=%h",
                        i, got_q[i], exp_q[i]);
            end
         end
         n_chk++;
         if (got_q[0] !== d || got_q[3] !== d) begin
            n_fail++;
            $display("FAIL b2b_alias got=%h required=%h", got_q[3], d);
         end
      end
   endtask

   task automatic test_misaligned();
      logic [DW-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      clear_obs();
      n_chk++;
      if (app.protocol_err !== 1'b0) begin
         n_fail++;
         $display("FAIL misal_pre got=%b required=0", app.protocol_err);
      end
      send_cmd(3'b000, 28'h000_0000);
      send_beat(d, '0, 1'b1);
      send_cmd(3'b001, 28'h000_0803);
      n_chk++;
      if (app.protocol_err !== 1'b1) begin
         n_fail++;
         $display("FAIL misal_err got=%b required=1", app.protocol_err);
      end
      wait_reads(1);
      if (got_q.size() >= 1) begin
         n_chk++;
         if (got_q[0] !== d) begin
            n_fail++;
            $display("FAIL misal_alias got=%h required=%h", got_q[0], d);
         end
      end
      idle(6);
      n_chk++;
      if (app.protocol_err !== 1'b1) begin
         n_fail++;
         $display("FAIL misal_sticky got=%b required=1", app.protocol_err);
      end
      pulse_reset();
      n_chk++;
      if (app.protocol_err !== 1'b0) begin
         n_fail++;
         $display("FAIL misal_clear got=%b required=0", app.protocol_err);
      end
      wait_calib();
   endtask

   task automatic test_proto_err();
      logic [DW-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      clear_obs();
      send_cmd(3'b011, 28'h000_0040);
      n_chk++;
      if (app.protocol_err !== 1'b1) begin
         n_fail++;
         $display("FAIL badop_err got=%b required=1", app.protocol_err);
      end
      pulse_reset();
      wait_calib();
      send_cmd(3'b000, 28'h000_0040);
      send_beat(d, '0, 1'b0);
      n_chk++;
      if (app.protocol_err !== 1'b1) begin
         n_fail++;
         $display("FAIL wdfend_err got=%b required=1", app.protocol_err);
      end
      send_cmd(3'b001, 28'h000_0040);
      wait_reads(1);
      if (got_q.size() >= 1) begin
         n_chk++;
         if (got_q[0] !== d) begin
            n_fail++;
            $display("FAIL wdfend_data got=%h required=%h", got_q[0], d);
         end
      end
      pulse_reset();
      wait_calib();
   endtask

   function automatic logic [AW-1:0] rand_addr(input int w);
      int hi;
      hi = $urandom_range(0, 1023);
      return AW'(((hi * MD) + 8 + w) * 8);
   endfunction

   task automatic test_random();
      bit            rd [$];
      logic [AW-1:0] ad [$];
      logic [DW-1:0] bd [$];
      logic [BY-1:0] bm [$];
      int            nr;
      bit            r;
      clear_obs();
      nr = 0;
      for (int i = 0; i < 8; i++) begin
         rd.push_back(1'b0);
         ad.push_back(rand_addr(i));
         bd.push_back({$urandom, $urandom, $urandom, $urandom});
         bm.push_back('0);
      end
      for (int i = 0; i < 40; i++) begin
         r = 1'($urandom_range(0, 1));
         rd.push_back(r);
         ad.push_back(rand_addr($urandom_range(0, 7)));
         if (r) nr++;
         else begin
            bd.push_back({$urandom, $urandom, $urandom, $urandom});
            bm.push_back(BY'($urandom));
         end
      end
      fork
         for (int i = 0; i < rd.size(); i++) begin
            send_cmd(rd[i] ? 3'b001 : 3'b000, ad[i]);
            if ($urandom_range(0, 3) == 0) idle(1);
         end
         for (int j = 0; j < bd.size(); j++) begin
            idle($urandom_range(0, 2));
            send_beat(bd[j], bm[j], 1'b1);
         end
      join
      wait_reads(nr);
      n_chk++;
      if (got_q.size() !== nr || exp_q.size() !== nr) begin
         n_fail++;
         $display("FAIL rand_count got=%0d required=%0d",
                  got_q.size(), nr);
      end else begin
         for (int i = 0; i < nr; i++) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL rand_data%0d got=%h required=%h",
                        i, got_q[i], exp_q[i]);
            end
         end
      end
      n_chk++;
      if (end_mis !== 0) begin
         n_fail++;
         $display("FAIL end_vs_valid got=%0d required=0", end_mis);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_mask();
      test_delayed_data();
      test_back_to_back();
      test_misaligned();
      test_proto_err();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
